// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared types and constants for the data memory responder.
//   mem_state_t : responder FSM states
//   F3_*        : RV32I load/store funct3 size codes (stores reuse 0/1/2)
//   f3_illegal  : funct3 legality check for a given direction
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Codes 3/6/7 are never valid; the unsigned variants only exist for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        logic bad;
        case (f3)
            F3_LB, F3_LH, F3_LW: bad = 1'b0;
            F3_LBU, F3_LHU:      bad = we;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational byte/half lane steering for RV32I loads and stores.
//   i_funct3  : size/sign code (assumed legal by the caller)
//   i_lane    : addr[1:0] byte lane
//   i_old     : current memory word
//   i_wdata   : right-aligned store data
//   o_merged  : word to write back (only addressed lanes replaced)
//   o_load    : extracted and sign/zero-extended load value
// ---------------------------------------------------------------------------
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_sh   = {i_lane, 3'b000};
    assign w_byte = 8'(i_old >> w_sh);
    assign w_half = i_lane[1] ? i_old[31:16] : i_old[15:0];

    always_comb begin
        o_load = i_old;
        case (i_funct3)
            F3_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_load = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_load = {24'd0, w_byte};
            F3_LHU:  o_load = {16'd0, w_half};
            default: o_load = i_old;
        endcase
    end

    // Store sizes are keyed on funct3[1:0] only; store funct3 is 0/1/2.
    always_comb begin
        o_merged = i_old;
        case (i_funct3[1:0])
            2'd0: o_merged = (i_old & ~(32'h0000_00FF << w_sh))
                           | ({24'd0, i_wdata[7:0]} << w_sh);
            2'd1: begin
                if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
                else           o_merged[15:0]  = i_wdata[15:0];
            end
            2'd2: o_merged = i_wdata;
            default: o_merged = i_old;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Load/store responder with configurable wait states over a word array.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid/ready, req_we, req_funct3, req_addr, req_wdata : request channel
//   rsp_valid/ready, rsp_rdata, rsp_err                      : response channel
// One transaction in flight. Errors (illegal funct3, misaligned, out of
// range) respond after one cycle and never touch memory.
// ---------------------------------------------------------------------------
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mem_state_t     r_state, w_next;
    logic           r_req_ready;
    logic [CW-1:0]  r_cnt;
    logic           r_we;
    logic [2:0]     r_f3;
    logic [AW+1:0]  r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic           r_err;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_accept;
    logic           w_mis;
    logic           w_oor;
    logic           w_req_err;
    logic           w_do_access;
    logic           w_acc_we;
    logic [2:0]     w_acc_f3;
    logic [AW+1:0]  w_acc_addr;
    logic [31:0]    w_acc_wdata;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_merged;
    logic [31:0]    w_load;

    // ---- request checks (on the live request, evaluated at accept) -------
    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_mis     = ((req_funct3[1:0] == 2'd1) && req_addr[0])
                     || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    assign w_oor     = |req_addr[31:AW+2];
    assign w_req_err = f3_illegal(req_funct3, req_we) || w_mis || w_oor;

    // With zero wait states the access happens in the accept cycle, so the
    // datapath must see the live request instead of the latched copy.
    assign w_acc_we    = (r_state == IDLE) ? req_we               : r_we;
    assign w_acc_f3    = (r_state == IDLE) ? req_funct3           : r_f3;
    assign w_acc_addr  = (r_state == IDLE) ? req_addr[AW+1:0]     : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata            : r_wdata;
    assign w_idx       = w_acc_addr[AW+1:2];

    assign w_do_access = ((WAIT_CYCLES == 0) && w_accept && !w_req_err)
                      || ((r_state == WAIT) && (r_cnt == '0));

    mem_lane_align u_align (
        .i_funct3 (w_acc_f3),
        .i_lane   (w_acc_addr[1:0]),
        .i_old    (r_mem[w_idx]),
        .i_wdata  (w_acc_wdata),
        .o_merged (w_merged),
        .o_load   (w_load)
    );

    // ---- FSM -------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err || (WAIT_CYCLES == 0)) w_next = RESP;
                    else                                 w_next = WAIT;
                end
            end
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    if (rsp_ready)   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered so that it is low in the reset cycle and never depends
    // combinationally on req_valid/rsp_ready.
    always_ff @(posedge clk) begin
        if (rst) r_req_ready <= 1'b0;
        else     r_req_ready <= (w_next == IDLE);
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // ---- datapath and memory --------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[AW+1:0];
                r_wdata <= req_wdata;
                r_err   <= w_req_err;
                if (w_req_err)                         r_rdata <= '0;
                else if (WAIT_CYCLES > 0)              r_cnt   <= CNT_INIT;
            end

            if ((r_state == WAIT) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;

            if (w_do_access) begin
                if (w_acc_we) begin
                    r_mem[w_idx] <= w_merged;
                    r_rdata      <= '0;
                end else begin
                    r_rdata      <= w_load;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        d0_req_valid, d0_req_ready, d0_req_we, d0_rsp_valid, d0_rsp_ready, d0_rsp_err;
    logic [2:0]  d0_req_funct3;
    logic [31:0] d0_req_addr, d0_req_wdata, d0_rsp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    // Byte-addressed reference memory, 256 words.
    logic [7:0] mb [1024];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_we(d0_req_we),
        .req_funct3(d0_req_funct3), .req_addr(d0_req_addr), .req_wdata(d0_req_wdata),
        .rsp_valid(d0_rsp_valid), .rsp_ready(d0_rsp_ready),
        .rsp_rdata(d0_rsp_rdata), .rsp_err(d0_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    endtask

    // Reference behaviour from the ISA rules: size, alignment, range, extension.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int size;
        logic [31:0] v;
        er = 1'b0; rd = 32'd0; size = 1;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    er = 1'b1;
        endcase
        if (we && f3 >= 3'd4) er = 1'b1;
        if (addr >= 32'd1024) er = 1'b1;
        if ((addr % size) != 0) er = 1'b1;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < size; i++) mb[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(mb[int'(addr) + i]) << (8*i));
                if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    // One full transaction; called #1 after a rising edge. hold>0 keeps
    // rsp_ready low (and req_valid high) for that many response cycles.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
        logic [31:0] exp_rd;
        logic        exp_er;
        int g, lat;
        model(we, f3, addr, wdata, exp_rd, exp_er);
        g = 0;
        while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
        chk("req_ready_wait", 32'(g < 20), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        if (hold == 0) req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", 32'(lat), exp_er ? 32'd1 : 32'd3);
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", 32'(rsp_err), 32'(exp_er));
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk("bp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_rdata", rsp_rdata, exp_rd);
                chk("bp_req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            req_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
        d0_req_valid = 0; d0_req_we = 0; d0_req_funct3 = 0; d0_req_addr = 0; d0_req_wdata = 0;
        d0_rsp_ready = 1;
        model_clear();
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Directed cases
        txn(1, 3'd2, 32'h10,  32'hDEADBEEF, 0);   // SW
        txn(0, 3'd2, 32'h10,  32'h0,        0);   // LW
        txn(1, 3'd0, 32'h11,  32'h00000080, 0);   // SB
        txn(0, 3'd2, 32'h10,  32'h0,        0);   // LW -> DEAD80EF
        txn(0, 3'd0, 32'h11,  32'h0,        0);   // LB
        txn(0, 3'd4, 32'h11,  32'h0,        0);   // LBU
        txn(1, 3'd1, 32'h12,  32'h0000CAFE, 0);   // SH upper half
        txn(0, 3'd5, 32'h12,  32'h0,        0);   // LHU
        txn(0, 3'd1, 32'h13,  32'h0,        0);   // LH misaligned
        txn(1, 3'd2, 32'h400, 32'h11111111, 0);   // SW out of range
        txn(0, 3'd2, 32'h0,   32'h0,        0);   // word 0 untouched
        txn(1, 3'd4, 32'h20,  32'h5,        0);   // illegal store funct3
        txn(0, 3'd3, 32'h20,  32'h0,        0);   // illegal funct3
        txn(0, 3'd2, 32'h10,  32'h0,        5);   // backpressure

        // Reset while a store is waiting
        req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        chk("midrst_idle", 32'(req_ready), 32'd1);
        txn(0, 3'd2, 32'h20, 32'h0, 0);

        // Randomized traffic
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = 32'($urandom_range(0, 1023));
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 0);
        end

        // Zero-wait build: one-cycle latency, accept every other cycle
        d0_req_valid = 1; d0_req_we = 1; d0_req_funct3 = 3'd2; d0_req_addr = 32'h8;
        d0_req_wdata = 32'h000055AA;
        @(posedge clk); #1;
        chk("w0_sw_valid", 32'(d0_rsp_valid), 32'd1);
        chk("w0_sw_err", 32'(d0_rsp_err), 32'd0);
        d0_req_we = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("w0_valid", 32'(d0_rsp_valid), 32'(k % 2));
            chk("w0_ready", 32'(d0_req_ready), 32'((k + 1) % 2));
            if (d0_rsp_valid) chk("w0_rdata", d0_rsp_rdata, 32'h000055AA);
        end
        d0_req_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
